// File: rtl/sensores_pkg.sv
// Shared definitions for the sensor sweep controller: FSM states, sensor
// indices and the widths used by the averaging arithmetic.
package sensores_pkg;

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        PEDE    = 3'd1,
        PROXIMO = 3'd2,
        SOMA    = 3'd3,
        DIVIDE  = 3'd4,
        PUBLICA = 3'd5,
        ESPERA  = 3'd6
    } estado_t;

    localparam logic [1:0] SENSOR_TEMP = 2'd0;
    localparam logic [1:0] SENSOR_PH   = 2'd1;
    localparam logic [1:0] SENSOR_LUM  = 2'd2;
    localparam logic [1:0] SENSOR_UMID = 2'd3;

    // Sum of four 4-bit readings fits in 6 bits (max 60).
    localparam int LARGURA_SOMA  = 6;
    // 6-bit dividend / 3 fits in 5 bits (max 21).
    localparam int LARGURA_QUOC  = 5;
    localparam int ITERACOES_DIV = 6;
    localparam int NOTA_MAX      = 15;

endpackage

// File: rtl/divisor_por_tres.sv
// Restoring divider by the constant 3: one quotient bit per clock.
// The first iteration is taken on the start edge, so o_pronto rises exactly
// ITERACOES_DIV cycles after the cycle in which i_inicio is high, with the
// final quotient already registered on o_quociente.
module divisor_por_tres
    import sensores_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    i_inicio,
    input  logic [LARGURA_SOMA-1:0] i_dividendo,
    output logic [LARGURA_QUOC-1:0] o_quociente,
    output logic                    o_pronto
);

    logic [LARGURA_SOMA-1:0] r_dividendo;
    logic [1:0]              r_resto;
    logic [LARGURA_QUOC-1:0] r_quoc;
    logic [2:0]              r_restantes;
    logic                    r_pronto;

    logic                    w_bit;
    logic [1:0]              w_resto_base;
    logic [2:0]              w_passo;

    // One restoring step: returns {quotient bit, new remainder}.
    // The remainder is always < 3, so the shifted value is < 6.
    function automatic logic [2:0] passo_divisao(input logic [1:0] resto, input logic bit_in);
        logic [2:0] t;
        t = {resto, bit_in};
        if (t >= 3'd3) begin
            passo_divisao = {1'b1, 2'(t - 3'd3)};
        end else begin
            passo_divisao = {1'b0, t[1:0]};
        end
    endfunction

    assign w_bit        = i_inicio ? i_dividendo[LARGURA_SOMA-1] : r_dividendo[LARGURA_SOMA-1];
    assign w_resto_base = i_inicio ? 2'b00 : r_resto;
    assign w_passo      = passo_divisao(w_resto_base, w_bit);

    // Shift dividend bits in MSB first, accumulating quotient bits.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_dividendo <= '0;
            r_resto     <= '0;
            r_quoc      <= '0;
            r_restantes <= '0;
            r_pronto    <= 1'b0;
        end else if (i_inicio) begin
            r_dividendo <= {i_dividendo[LARGURA_SOMA-2:0], 1'b0};
            r_resto     <= w_passo[1:0];
            r_quoc      <= {{(LARGURA_QUOC-1){1'b0}}, w_passo[2]};
            r_restantes <= 3'(ITERACOES_DIV - 1);
            r_pronto    <= 1'b0;
        end else if (r_restantes != 3'd0) begin
            r_dividendo <= {r_dividendo[LARGURA_SOMA-2:0], 1'b0};
            r_resto     <= w_passo[1:0];
            // The quotient MSB of a 6-bit/3 division is always 0 and drops out here.
            r_quoc      <= {r_quoc[LARGURA_QUOC-2:0], w_passo[2]};
            r_restantes <= r_restantes - 3'd1;
            r_pronto    <= (r_restantes == 3'd1);
        end else begin
            r_pronto    <= 1'b0;
        end
    end

    assign o_quociente = r_quoc;
    assign o_pronto    = r_pronto;

endmodule

// File: rtl/sequenciador_sensores.sv
// Periodic sweep controller: polls four sensors over one req/ack channel,
// averages them as floor(sum/3) saturated to 15 and publishes the readings
// and the nota with a one-cycle nota_valida pulse.
// Optional feature macro: MEDICAO_TIMEOUT_EN (per-sensor ack timeout with
// erro_sensor flags). Without it PEDE waits forever and erro_sensor is 0.
module sequenciador_sensores
    import sensores_pkg::*;
#(
    parameter int LARGURA         = 4,
    parameter int PERIODO_AMOSTRA = 1000,
    parameter int TIMEOUT_CICLOS  = 255
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               enable,
    output logic [1:0]         sensor_sel,
    output logic               sensor_req,
    input  logic               sensor_ack,
    input  logic [LARGURA-1:0] sensor_dado,
    output logic [LARGURA-1:0] temperatura,
    output logic [LARGURA-1:0] pH,
    output logic [LARGURA-1:0] luminosidade,
    output logic [LARGURA-1:0] umidade,
    output logic [LARGURA-1:0] nota,
    output logic               nota_valida,
    output logic               ocupado,
    output logic [3:0]         erro_sensor
);

    localparam int W_INT = $clog2(PERIODO_AMOSTRA + 1);

    if (PERIODO_AMOSTRA < 1 || TIMEOUT_CICLOS < 1 || LARGURA != 4) begin : g_parametros_invalidos
        $error("sequenciador_sensores: invalid parameter set");
    end

    estado_t                 r_estado;
    estado_t                 w_prox;
    logic [1:0]              r_sel;
    logic                    r_parar;
    logic [LARGURA-1:0]      r_sombra [4];
    logic [LARGURA-1:0]      r_temperatura;
    logic [LARGURA-1:0]      r_ph;
    logic [LARGURA-1:0]      r_luminosidade;
    logic [LARGURA-1:0]      r_umidade;
    logic [LARGURA-1:0]      r_nota;
    logic [W_INT-1:0]        r_cont_int;

    logic                    w_captura;
    logic                    w_expirou;
    logic                    w_fim_intervalo;
    logic                    w_inicio_div;
    logic                    w_div_pronto;
    logic                    w_publica;
    logic [LARGURA_SOMA-1:0] w_soma;
    logic [LARGURA_QUOC-1:0] w_quociente;

    function automatic logic [LARGURA-1:0] satura_nota(input logic [LARGURA_QUOC-1:0] q);
        if (q > LARGURA_QUOC'(NOTA_MAX)) begin
            satura_nota = LARGURA'(NOTA_MAX);
        end else begin
            satura_nota = LARGURA'(q);
        end
    endfunction

    assign w_captura       = (r_estado == PEDE) && sensor_ack;
    assign w_fim_intervalo = (r_cont_int == W_INT'(PERIODO_AMOSTRA - 1));
    assign w_publica       = (r_estado == DIVIDE) && w_div_pronto;
    assign w_soma          = LARGURA_SOMA'(r_sombra[SENSOR_TEMP]) + LARGURA_SOMA'(r_sombra[SENSOR_PH])
                           + LARGURA_SOMA'(r_sombra[SENSOR_LUM])  + LARGURA_SOMA'(r_sombra[SENSOR_UMID]);

`ifdef MEDICAO_TIMEOUT_EN
    localparam int W_TO = $clog2(TIMEOUT_CICLOS + 1);

    logic [W_TO-1:0] r_cont_to;
    logic [3:0]      r_erro;

    // Count cycles spent waiting for ack; restarts for every request.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cont_to <= '0;
        end else if (r_estado == PEDE && !sensor_ack) begin
            r_cont_to <= r_cont_to + W_TO'(1);
        end else begin
            r_cont_to <= '0;
        end
    end

    // A late ack on the expiry cycle still counts as success.
    assign w_expirou = (r_estado == PEDE) && (r_cont_to == W_TO'(TIMEOUT_CICLOS - 1));

    // Error flag per sensor: set on expiry, cleared by that sensor's next ack.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_erro <= 4'b0000;
        end else if (w_captura) begin
            r_erro[r_sel] <= 1'b0;
        end else if (w_expirou) begin
            r_erro[r_sel] <= 1'b1;
        end
    end

    assign erro_sensor = r_erro;
`else
    assign w_expirou   = 1'b0;
    assign erro_sensor = 4'b0000;
`endif

    divisor_por_tres u_divisor (
        .clock       (clock),
        .reset_n     (reset_n),
        .i_inicio    (w_inicio_div),
        .i_dividendo (w_soma),
        .o_quociente (w_quociente),
        .o_pronto    (w_div_pronto)
    );

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_estado <= OCIOSO;
        end else begin
            r_estado <= w_prox;
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        w_prox       = r_estado;
        sensor_req   = 1'b0;
        nota_valida  = 1'b0;
        ocupado      = 1'b1;
        w_inicio_div = 1'b0;
        case (r_estado)
            OCIOSO: begin
                ocupado = 1'b0;
                if (enable) begin
                    w_prox = PEDE;
                end
            end
            PEDE: begin
                sensor_req = 1'b1;
                if (sensor_ack || w_expirou) begin
                    w_prox = PROXIMO;
                end
            end
            PROXIMO: begin
                w_prox = (r_sel == SENSOR_UMID) ? SOMA : PEDE;
            end
            SOMA: begin
                w_inicio_div = 1'b1;
                w_prox       = DIVIDE;
            end
            DIVIDE: begin
                if (w_div_pronto) begin
                    w_prox = PUBLICA;
                end
            end
            PUBLICA: begin
                nota_valida = 1'b1;
                w_prox      = (enable && !r_parar) ? ESPERA : OCIOSO;
            end
            ESPERA: begin
                ocupado = 1'b0;
                if (!enable) begin
                    w_prox = OCIOSO;
                end else if (w_fim_intervalo) begin
                    w_prox = PEDE;
                end
            end
            default: begin
                w_prox = OCIOSO;
            end
        endcase
    end

    // Remember a mid-sweep enable drop so the sweep ends in OCIOSO.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_parar <= 1'b0;
        end else if (r_estado == OCIOSO || r_estado == ESPERA) begin
            r_parar <= 1'b0;
        end else if (!enable) begin
            r_parar <= 1'b1;
        end
    end

    // Sensor index: restart at temperatura between sweeps, advance in PROXIMO.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sel <= SENSOR_TEMP;
        end else if (r_estado == OCIOSO || r_estado == ESPERA) begin
            r_sel <= SENSOR_TEMP;
        end else if (r_estado == PROXIMO && r_sel != SENSOR_UMID) begin
            r_sel <= r_sel + 2'd1;
        end
    end

    // Idle interval counter, only runs while waiting in ESPERA.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cont_int <= '0;
        end else if (r_estado == ESPERA) begin
            r_cont_int <= r_cont_int + W_INT'(1);
        end else begin
            r_cont_int <= '0;
        end
    end

    // Shadow readings: captured on the req/ack edge, hidden until publication.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                r_sombra[i] <= '0;
            end
        end else if (w_captura) begin
            r_sombra[r_sel] <= sensor_dado;
        end
    end

    // Published outputs change together on the edge that enters PUBLICA.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_temperatura  <= '0;
            r_ph           <= '0;
            r_luminosidade <= '0;
            r_umidade      <= '0;
            r_nota         <= '0;
        end else if (w_publica) begin
            r_temperatura  <= r_sombra[SENSOR_TEMP];
            r_ph           <= r_sombra[SENSOR_PH];
            r_luminosidade <= r_sombra[SENSOR_LUM];
            r_umidade      <= r_sombra[SENSOR_UMID];
            r_nota         <= satura_nota(w_quociente);
        end
    end

    assign sensor_sel   = r_sel;
    assign temperatura  = r_temperatura;
    assign pH           = r_ph;
    assign luminosidade = r_luminosidade;
    assign umidade      = r_umidade;
    assign nota         = r_nota;

endmodule
